// File: rtl/nettlp_encap_if.sv
// Byte stream bundle (valid/ready, data, keep, last) shared by the TLP input
// and the frame output of the NetTLP encapsulator.
interface nettlp_encap_if #(
  parameter int DATA_W = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/nettlp_encap.sv
// NetTLP encapsulator: prepends a 48-byte Ethernet/IPv4/UDP/NetTLP header to
// each TLP and passes the TLP bytes through unchanged.
module nettlp_encap #(
  parameter int          DATA_W   = 64,
  parameter logic [9:0]  SEQ_INIT = 10'd0,
  parameter int unsigned TS_DIV   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  nettlp_encap_if.slave  s,
  nettlp_encap_if.master m,
  input  logic [10:0]    s_tlp_len_i,
  input  logic [47:0]    cfg_src_mac_i,
  input  logic [47:0]    cfg_dst_mac_i,
  input  logic [31:0]    cfg_src_ip_i,
  input  logic [31:0]    cfg_dst_ip_i,
  input  logic [15:0]    cfg_src_port_i,
  input  logic [15:0]    cfg_dst_port_i,
  input  logic           ts_en_i
);
  localparam int unsigned KW = DATA_W / 8;
  localparam int unsigned HB = 48 / KW;
  localparam int unsigned BW = $clog2(HB);

  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_HDR, S_PAY} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [9:0]     seq_q, seq_d;
  logic [15:0]    id_q, id_d;
  logic [31:0]    ts_q, ts_d, div_q, div_d;

  logic [47:0]    smac_q, dmac_q;
  logic [31:0]    sip_q, dip_q, hts_q;
  logic [15:0]    sport_q, dport_q, hid_q, csum_q;
  logic [10:0]    len_q;
  logic [9:0]     hseq_q;

  logic [15:0]    tot_in, csum_d, tot_len, udp_len;
  logic [19:0]    sum0;
  logic [16:0]    fold1;
  logic [15:0]    fold2;
  logic [383:0]   hdr;
  logic [DATA_W-1:0] hdr_beat;

  // Checksum is computed from the live inputs during CSUM, the same cycle they are latched.
  always_comb begin
    tot_in = {5'b0, s_tlp_len_i} + 16'd34;
    sum0   = 20'h04500 + 20'h04000 + 20'h04011 + {4'b0, tot_in} + {4'b0, id_q}
           + {4'b0, cfg_src_ip_i[31:16]} + {4'b0, cfg_src_ip_i[15:0]}
           + {4'b0, cfg_dst_ip_i[31:16]} + {4'b0, cfg_dst_ip_i[15:0]};
    fold1  = {1'b0, sum0[15:0]} + {13'b0, sum0[19:16]};
    fold2  = fold1[15:0] + {15'b0, fold1[16]};
    csum_d = ~fold2;
  end

  assign tot_len = {5'b0, len_q} + 16'd34;
  assign udp_len = {5'b0, len_q} + 16'd14;
  assign hdr = {dmac_q, smac_q, 16'h0800, 8'h45, 8'h00, tot_len, hid_q,
                16'h4000, 8'h40, 8'h11, csum_q, sip_q, dip_q,
                sport_q, dport_q, udp_len, 16'h0000, 6'b0, hseq_q, hts_q};

  always_comb begin
    hdr_beat = '0;
    for (int unsigned k = 0; k < HB; k++) begin
      if (beat_q == BW'(k)) hdr_beat = hdr[(HB-1-k)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ts_d  = ts_q;
    div_d = div_q;
    if (ts_en_i) begin
      if (div_q == TS_DIV - 1) begin
        div_d = '0;
        ts_d  = ts_q + 32'd1;
      end else begin
        div_d = div_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    seq_d    = seq_q;
    id_d     = id_q;
    s.tready = 1'b0;
    m.tvalid = 1'b0;
    m.tdata  = '0;
    m.tkeep  = '0;
    m.tlast  = 1'b0;
    case (state_q)
      S_IDLE: if (s.tvalid) state_d = S_CSUM;
      S_CSUM: begin
        state_d = S_HDR;
        beat_d  = '0;
      end
      S_HDR: begin
        m.tvalid = 1'b1;
        m.tdata  = hdr_beat;
        m.tkeep  = '1;
        if (m.tready) begin
          if (beat_q == BW'(HB - 1)) begin
            state_d = S_PAY;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_PAY: begin
        m.tvalid = s.tvalid;
        s.tready = m.tready;
        m.tdata  = s.tdata;
        m.tkeep  = s.tkeep;
        m.tlast  = s.tlast;
        if (s.tvalid && s.tlast && m.tready) begin
          seq_d   = seq_q + 10'd1;
          id_d    = id_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      seq_q   <= SEQ_INIT;
      id_q    <= '0;
      ts_q    <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      seq_q   <= seq_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      div_q   <= div_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smac_q <= '0; dmac_q <= '0; sip_q <= '0; dip_q <= '0;
      sport_q <= '0; dport_q <= '0; len_q <= '0; hid_q <= '0;
      hseq_q <= '0; hts_q <= '0; csum_q <= '0;
    end else if (state_q == S_CSUM) begin
      smac_q  <= cfg_src_mac_i;
      dmac_q  <= cfg_dst_mac_i;
      sip_q   <= cfg_src_ip_i;
      dip_q   <= cfg_dst_ip_i;
      sport_q <= cfg_src_port_i;
      dport_q <= cfg_dst_port_i;
      len_q   <= s_tlp_len_i;
      hid_q   <= id_q;
      hseq_q  <= seq_q;
      hts_q   <= ts_q;
      csum_q  <= csum_d;
    end
  end
endmodule
